// File: rtl/load_store_unit.sv
// Load/store unit: aligns core byte/half/word accesses onto a 32-bit word memory
// port and returns extended load data or an error cause.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [1:0]  rsp_cause,
  output logic        mem_r_v,
  output logic        mem_w_v,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_strobe,
  input  logic [31:0] mem_resp,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_MEM   = 2'b10;
  localparam logic [1:0] CAUSE_TOUT  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic [31:0]   adr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    cause_q;
  logic [CW-1:0] cnt_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_strobe = 4'b0001 << a;
      2'b01:   lane_strobe = 4'b0011 << a;
      default: lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (size)
      2'b00:   extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            rdata_q <= '0;
            cnt_q   <= '0;
            if (misaligned(req_size, req_adr[1:0])) begin
              cause_q <= CAUSE_ALIGN;
              state_q <= RESP;
            end else begin
              cause_q <= CAUSE_NONE;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Stores complete after one cycle; loads wait, but arriving data beats the timeout.
          if (we_q) begin
            cause_q <= mem_resp_error ? CAUSE_MEM : CAUSE_NONE;
            state_q <= RESP;
          end else if (mem_resp_valid) begin
            cause_q <= mem_resp_error ? CAUSE_MEM : CAUSE_NONE;
            rdata_q <= mem_resp_error ? 32'd0 : extract(mem_resp, size_q, adr_q[1:0], uns_q);
            state_q <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            cause_q <= CAUSE_TOUT;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_error  = 1'b0;
    rsp_cause  = '0;
    mem_r_v    = 1'b0;
    mem_w_v    = 1'b0;
    mem_adr    = '0;
    mem_data   = '0;
    mem_strobe = '0;
    if (state_q == ACCESS) begin
      mem_r_v    = ~we_q;
      mem_w_v    = we_q;
      mem_adr    = {adr_q[31:2], 2'b00};
      mem_data   = wdata_q << (8 * adr_q[1:0]);
      mem_strobe = lane_strobe(size_q, adr_q[1:0]);
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      rsp_data  = rdata_q;
      rsp_error = (cause_q != CAUSE_NONE);
      rsp_cause = cause_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a monitor pops and compares on each rsp_valid.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_adr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_cause;
  logic        mem_r_v, mem_w_v;
  logic [31:0] mem_adr, mem_data, mem_resp;
  logic [3:0]  mem_strobe;
  logic        mem_resp_valid, mem_resp_error;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [1:0]  c;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_cause(rsp_cause),
    .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr),
    .mem_data(mem_data), .mem_strobe(mem_strobe),
    .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
    .mem_resp_error(mem_resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Response monitor: compares every completion against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.d);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e.e});
        check("rsp_cause", {30'd0, rsp_cause}, {30'd0, e.c});
      end
    end else if ((rsp_data != 0) || rsp_error || (rsp_cause != 0)) begin
      check("rsp_idle_zero", {rsp_data[31:3], rsp_error, rsp_cause}, 32'd0);
    end
  end

  // Issues one request from IDLE (called #1 after a rising edge) and runs the memory side.
  // dly: ACCESS cycle index on which mem_resp_valid is driven, -1 = never.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] rword, input logic rerr, input int dly,
                        input int exp_cycles, input logic [3:0] exp_strb,
                        input logic [31:0] exp_mdata,
                        input logic [31:0] exp_d, input logic [1:0] exp_c);
    exp_t e;
    int cyc;
    e.d = exp_d; e.e = (exp_c != 2'b00); e.c = exp_c;
    sb.push_back(e);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (!(mem_r_v || mem_w_v)) break;
      if (k == 0) begin
        check("mem_w_v", {31'd0, mem_w_v}, {31'd0, we});
        check("mem_r_v", {31'd0, mem_r_v}, {31'd0, ~we});
        check("mem_adr", mem_adr, {adr[31:2], 2'b00});
        check("mem_strobe", {28'd0, mem_strobe}, {28'd0, exp_strb});
        check("mem_data", mem_data, exp_mdata);
      end
      cyc++;
      mem_resp_valid = (k == dly);
      mem_resp_error = rerr;
      mem_resp       = rword;
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0; mem_resp_error = 1'b0; mem_resp = '0;
    check("access_cycles", cyc, exp_cycles);
    check("rsp_valid_after_access", {31'd0, rsp_valid}, 32'd1);
    check("mem_strobe_outside_access", {28'd0, mem_strobe}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_adr = '0; req_wdata = '0; req_size = '0; req_unsigned = 0;
    mem_resp = '0; mem_resp_valid = 0; mem_resp_error = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mem_rw", {30'd0, mem_r_v, mem_w_v}, 32'd0);
    check("rst_mem_adr", mem_adr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_mem_strobe", {28'd0, mem_strobe}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // store byte to lane 3
    do_req(1, 32'h2003, 32'hAB, 2'b00, 0, 0, 0, 0, 1, 4'b1000, 32'hAB00_0000, 0, 2'b00);
    // load half signed / unsigned from upper half
    do_req(0, 32'h2002, 0, 2'b01, 0, 32'h8001_1234, 0, 0, 1, 4'b1100, 0, 32'hFFFF_8001, 2'b00);
    do_req(0, 32'h2002, 0, 2'b01, 1, 32'h8001_1234, 0, 0, 1, 4'b1100, 0, 32'h0000_8001, 2'b00);
    // misaligned word, size 11, misaligned half store
    do_req(0, 32'h2001, 0, 2'b10, 0, 0, 0, -1, 0, 4'b0000, 0, 0, 2'b01);
    do_req(0, 32'h3000, 0, 2'b11, 0, 0, 0, -1, 0, 4'b0000, 0, 0, 2'b01);
    do_req(1, 32'h3001, 32'h1234, 2'b01, 0, 0, 0, -1, 0, 4'b0000, 0, 0, 2'b01);
    // timeout, and data on the final edge
    do_req(0, 32'h3000, 0, 2'b10, 0, 32'h1111_2222, 0, -1, 16, 4'b1111, 0, 0, 2'b11);
    do_req(0, 32'h3000, 0, 2'b10, 0, 32'h1234_5678, 0, 15, 16, 4'b1111, 0, 32'h1234_5678, 2'b00);
    // memory error on load and on store
    do_req(0, 32'h3004, 0, 2'b10, 0, 32'hDEAD_BEEF, 1, 2, 3, 4'b1111, 0, 0, 2'b10);
    do_req(1, 32'h1002, 32'hBEEF, 2'b01, 0, 0, 1, 0, 1, 4'b1100, 32'hBEEF_0000, 0, 2'b10);
    // byte loads, word store
    do_req(0, 32'h0101, 0, 2'b00, 0, 32'h0000_8000, 0, 1, 2, 4'b0010, 0, 32'hFFFF_FF80, 2'b00);
    do_req(0, 32'h0102, 0, 2'b00, 1, 32'hFF55_0000, 0, 0, 1, 4'b0100, 0, 32'h0000_0055, 2'b00);
    do_req(1, 32'h4000, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 2'b00);

    // reset in the middle of a load access
    req_valid = 1; req_we = 0; req_adr = 32'h5000; req_size = 2'b10; req_unsigned = 0;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_before_r_v", {31'd0, mem_r_v}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_r_v_drop", {31'd0, mem_r_v}, 32'd0);
    check("midrst_strobe", {28'd0, mem_strobe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
